// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction controller.
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHECK  = 2'b01,
    UPDATE = 2'b10,
    RESP   = 2'b11
  } state_t;

  typedef enum logic {
    DEP = 1'b0,
    WD  = 1'b1
  } req_t;

  localparam logic [1:0] ERR_ZERO  = 2'd0;
  localparam logic [1:0] ERR_INSUF = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_LIMIT = 2'd3;

endpackage

// File: rtl/atm_txn_ctrl_if.sv
// Front-end / balance-side signal bundle of the ATM transaction controller.
interface atm_txn_ctrl_if #(parameter int AW = 16);
  logic          card_in;
  logic          dep_req;
  logic          wd_req;
  logic [AW-1:0] amount;
  logic [AW-1:0] balance;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic          count_up;
  logic          sess_end;

  modport master (
    output card_in, dep_req, wd_req, amount,
    input  balance, busy, done, err, err_code, count_up, sess_end
  );

  modport slave (
    input  card_in, dep_req, wd_req, amount,
    output balance, busy, done, err, err_code, count_up, sess_end
  );
endinterface

// File: rtl/atm_sess_timer.sv
// Session supervision: idle timeout, card-removal detect, sess_end pulse and
// the post-timeout lockout that holds until the card is withdrawn.
module atm_sess_timer #(
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_card_in,
  input  logic i_idle,
  input  logic i_update,
  input  logic i_grant,
  output logic o_allow,
  output logic o_sess_clr,
  output logic o_sess_end
);

  logic [TW-1:0] r_tmr;
  logic          r_card_d;
  logic          r_rm_pend;
  logic          r_lock;
  logic          r_sess_end;
  logic          w_fall;
  logic          w_tmo;
  logic          w_rm;

  assign w_fall = r_card_d & ~i_card_in;
  assign w_tmo  = i_idle & i_card_in & ~r_lock & (r_tmr == TW'(TIMEOUT - 1));
  // A removal seen during UPDATE waits until the commit has reached RESP.
  assign w_rm   = (r_rm_pend | w_fall) & ~i_update & ~r_lock;

  assign o_sess_clr = w_tmo | w_rm;
  assign o_allow    = i_card_in & ~r_lock & ~w_tmo;
  assign o_sess_end = r_sess_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr      <= '0;
      r_card_d   <= 1'b0;
      r_rm_pend  <= 1'b0;
      r_lock     <= 1'b0;
      r_sess_end <= 1'b0;
    end else begin
      r_card_d   <= i_card_in;
      r_sess_end <= o_sess_clr;
      r_rm_pend  <= (r_rm_pend | w_fall) & ~w_rm & ~r_lock;
      if (!i_card_in)
        r_lock <= 1'b0;
      else if (w_tmo)
        r_lock <= 1'b1;
      if (!i_card_in || i_grant || o_sess_clr || !i_idle)
        r_tmr <= '0;
      else if (!r_lock)
        r_tmr <= r_tmr + TW'(1);
    end
  end

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM transaction controller: arbitrates deposit/withdraw requests, validates
// them against balance and session limits, and commits one update per grant.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int AW      = 16,
  parameter int MAX_WD  = 3,
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic           clk,
  input  logic           res,
  atm_txn_ctrl_if.slave  bus
);

  localparam int CW = $clog2(MAX_WD + 1);

  state_t        r_state, w_next;
  req_t          r_type, r_last, w_gtype;
  logic [AW-1:0] r_amt, r_bal;
  logic [CW-1:0] r_wd_cnt;
  logic [AW:0]   w_sum;
  logic          w_any_req, w_grant, w_allow, w_sess_clr;
  logic          w_idle, w_upd;
  logic          w_chk_err;
  logic [1:0]    w_chk_code;
  logic          r_done, r_err, r_cu, r_busy;
  logic [1:0]    r_code;
  logic          w_done_n, w_err_n, w_cu_n, w_busy_n;

  assign w_idle = (r_state == IDLE);
  assign w_upd  = (r_state == UPDATE);

  atm_sess_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk        (clk),
    .rst        (res),
    .i_card_in  (bus.card_in),
    .i_idle     (w_idle),
    .i_update   (w_upd),
    .i_grant    (w_grant),
    .o_allow    (w_allow),
    .o_sess_clr (w_sess_clr),
    .o_sess_end (bus.sess_end)
  );

  // Simultaneous requests alternate, favouring the type not granted last.
  always_comb begin
    w_any_req = bus.dep_req | bus.wd_req;
    w_grant   = w_idle & w_allow & w_any_req;
    if (bus.dep_req && bus.wd_req)
      w_gtype = (r_last == WD) ? DEP : WD;
    else
      w_gtype = bus.dep_req ? DEP : WD;
  end

  // Error priority: zero amount, withdraw limit, insufficient funds, overflow.
  always_comb begin
    w_sum      = {1'b0, r_bal} + {1'b0, r_amt};
    w_chk_err  = 1'b1;
    w_chk_code = ERR_ZERO;
    if (r_amt == '0)
      w_chk_code = ERR_ZERO;
    else if (r_type == WD && r_wd_cnt == CW'(MAX_WD))
      w_chk_code = ERR_LIMIT;
    else if (r_type == WD && r_amt > r_bal)
      w_chk_code = ERR_INSUF;
    else if (r_type == DEP && w_sum[AW])
      w_chk_code = ERR_OVF;
    else
      w_chk_err = 1'b0;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = CHECK;
      CHECK:   begin
        if (!bus.card_in)
          w_next = IDLE;
        else if (w_chk_err)
          w_next = RESP;
        else
          w_next = UPDATE;
      end
      UPDATE:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_done_n = w_upd;
    w_cu_n   = w_upd & (r_type == DEP);
    w_err_n  = (r_state == CHECK) & bus.card_in & w_chk_err;
    w_busy_n = (w_next != IDLE);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_cu   <= 1'b0;
      r_busy <= 1'b0;
      r_code <= ERR_ZERO;
    end else begin
      r_done <= w_done_n;
      r_err  <= w_err_n;
      r_cu   <= w_cu_n;
      r_busy <= w_busy_n;
      if (w_err_n)
        r_code <= w_chk_code;
    end
  end

  // Captured request: only meaningful after a grant, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_amt  <= bus.amount;
      r_type <= w_gtype;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_last   <= WD;
      r_bal    <= '0;
      r_wd_cnt <= '0;
    end else begin
      if (w_grant)
        r_last <= w_gtype;
      if (w_upd)
        r_bal <= (r_type == DEP) ? w_sum[AW-1:0] : (r_bal - r_amt);
      if (w_sess_clr)
        r_wd_cnt <= '0;
      else if (w_upd && r_type == WD)
        r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  assign bus.balance  = r_bal;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_code;
  assign bus.count_up = r_cu;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Self-checking bench for atm_txn_ctrl: vector table through a response
// scoreboard, plus hand sequences for timeout, card removal and reset.
module tb_atm_txn_ctrl;
  import atm_pkg::*;

  localparam int AW = 16;

  typedef struct {
    logic          tog;
    logic          dep;
    logic          wd;
    logic [AW-1:0] amt;
    logic          err;
    logic [1:0]    code;
    logic          cu;
    logic [AW-1:0] bal;
  } vec_t;

  typedef struct {
    logic          err;
    logic [1:0]    code;
    logic          cu;
    logic [AW-1:0] bal;
  } exp_t;

  logic clk;
  logic res;
  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vt[20];

  atm_txn_ctrl_if #(.AW(AW)) bus ();

  atm_txn_ctrl #(.AW(AW), .MAX_WD(3), .TIMEOUT(1000), .TW(10)) u_dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every done/err pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!res && (bus.done || bus.err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'({bus.done, bus.err}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_flags", 32'({bus.done, bus.err, bus.count_up}), 32'({~e.err, e.err, e.cu}));
        chk("resp_bal", 32'(bus.balance), 32'(e.bal));
        if (e.err) chk("resp_code", 32'(bus.err_code), 32'(e.code));
      end
    end
  end

  task automatic toggle_card();
    @(negedge clk) bus.card_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.card_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_txn(input vec_t v);
    int k;
    if (v.tog) toggle_card();
    sb.push_back('{err: v.err, code: v.code, cu: v.cu, bal: v.bal});
    @(negedge clk);
    bus.dep_req = v.dep;
    bus.wd_req  = v.wd;
    bus.amount  = v.amt;
    @(negedge clk);
    bus.dep_req = 1'b0;
    bus.wd_req  = 1'b0;
    chk("busy_after_grant", 32'(bus.busy), 32'd1);
    k = 1;
    while (!(bus.done || bus.err) && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("resp_latency", 32'(k), v.err ? 32'd2 : 32'd3);
    @(negedge clk);
  endtask

  initial begin
    int k;
    int n_se;
    checks = 0;
    errors = 0;
    res = 1'b1;
    bus.card_in = 1'b0;
    bus.dep_req = 1'b0;
    bus.wd_req  = 1'b0;
    bus.amount  = '0;

    //        tog  dep  wd   amt     err  code cu   bal
    vt[0]  = '{1'b0, 1'b1, 1'b0, 16'd50,    1'b0, 2'd0, 1'b1, 16'd50};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 16'd80,    1'b1, 2'd1, 1'b0, 16'd50};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 16'd10,    1'b0, 2'd0, 1'b1, 16'd60};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 16'd5,     1'b0, 2'd0, 1'b0, 16'd55};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 16'd45,    1'b0, 2'd0, 1'b1, 16'd100};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'd99};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'd98};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'd97};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 16'd1,     1'b1, 2'd3, 1'b0, 16'd97};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'd96};
    vt[10] = '{1'b0, 1'b1, 1'b0, 16'd0,     1'b1, 2'd0, 1'b0, 16'd96};
    vt[11] = '{1'b0, 1'b1, 1'b0, 16'd65439, 1'b0, 2'd0, 1'b1, 16'hFFFF};
    vt[12] = '{1'b0, 1'b1, 1'b0, 16'd1,     1'b1, 2'd2, 1'b0, 16'hFFFF};
    vt[13] = '{1'b0, 1'b0, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'hFFFE};
    vt[14] = '{1'b0, 1'b0, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'hFFFD};
    vt[15] = '{1'b0, 1'b0, 1'b1, 16'hFFFF,  1'b1, 2'd3, 1'b0, 16'hFFFD};
    vt[16] = '{1'b0, 1'b0, 1'b1, 16'd0,     1'b1, 2'd0, 1'b0, 16'hFFFD};
    vt[17] = '{1'b1, 1'b0, 1'b1, 16'hFFFF,  1'b1, 2'd1, 1'b0, 16'hFFFD};
    vt[18] = '{1'b0, 1'b1, 1'b1, 16'd2,     1'b0, 2'd0, 1'b1, 16'hFFFF};
    vt[19] = '{1'b0, 1'b1, 1'b1, 16'd1,     1'b0, 2'd0, 1'b0, 16'hFFFE};

    repeat (2) @(negedge clk);
    chk("reset_balance", 32'(bus.balance), 32'd0);
    chk("reset_flags", 32'({bus.busy, bus.done, bus.err, bus.count_up, bus.sess_end, bus.err_code}), 32'd0);
    res = 1'b0;
    bus.card_in = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) do_txn(vt[i]);

    // Idle timeout: card re-inserted, then left untouched.
    bus.card_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.card_in = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.sess_end && k < 1200);
    chk("timeout_cycles", 32'(k), 32'd1000);
    n_se = 0;
    bus.dep_req = 1'b1;
    bus.amount  = 16'd7;
    @(negedge clk);
    bus.dep_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.sess_end) n_se++;
      chk("locked_not_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end
    chk("timeout_single_pulse", 32'(n_se), 32'd0);
    chk("locked_balance", 32'(bus.balance), 32'hFFFE);
    do_txn('{1'b1, 1'b1, 1'b0, 16'd1, 1'b0, 2'd0, 1'b1, 16'hFFFF});

    // Card pulled while the request is in CHECK: silent abort.
    @(negedge clk);
    bus.wd_req = 1'b1;
    bus.amount = 16'd1;
    @(negedge clk);
    bus.wd_req  = 1'b0;
    bus.card_in = 1'b0;
    @(negedge clk);
    chk("abort_sess_end", 32'(bus.sess_end), 32'd1);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_balance", 32'(bus.balance), 32'hFFFF);

    // Card pulled during UPDATE: commit finishes, sess_end follows RESP.
    bus.card_in = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back('{err: 1'b0, code: 2'd0, cu: 1'b0, bal: 16'hFFF0});
    bus.wd_req = 1'b1;
    bus.amount = 16'd15;
    @(negedge clk);
    bus.wd_req = 1'b0;
    @(negedge clk);
    bus.card_in = 1'b0;
    @(negedge clk);
    chk("upd_drop_done", 32'(bus.done), 32'd1);
    chk("upd_drop_no_se_yet", 32'(bus.sess_end), 32'd0);
    @(negedge clk);
    chk("upd_drop_sess_end", 32'(bus.sess_end), 32'd1);
    chk("upd_drop_idle", 32'(bus.busy), 32'd0);
    bus.card_in = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a transaction.
    bus.dep_req = 1'b1;
    bus.amount  = 16'd9;
    @(negedge clk);
    bus.dep_req = 1'b0;
    #2 res = 1'b1;
    #1;
    chk("midreset_balance", 32'(bus.balance), 32'd0);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);
    do_txn('{1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 2'd0, 1'b1, 16'd5});

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/atm_txn_ctrl.md
Name: atm_txn_ctrl

Overview:
- Transaction controller for the ATM balance datapath.
- Accepts deposit and withdraw requests from the keypad/front-end during a card session and arbitrates between them.
- Validates each request against the balance and session limits, then commits exactly one balance update per granted request.
- Emits a one-cycle count_up pulse per committed deposit, driving the existing deposit counter path. Sits between the user-input front-end and the balance register / display logic.

Parameters:
- AW, 16, width of amount and balance in currency units
- MAX_WD, 3, maximum committed withdrawals per card session
- TIMEOUT, 1000, idle cycles in a session before forced session end
- TW, 10, width of the timeout counter; must satisfy 2**TW > TIMEOUT

Ports:
- clk  input  1  system clock, rising edge
- res  input  1  asynchronous active-high reset
- card_in  input  1  level; high while a card session is active
- dep_req  input  1  deposit request pulse; sampled only in IDLE
- wd_req  input  1  withdraw request pulse; sampled only in IDLE
- amount  input  AW  transaction amount; captured with the grant
- balance  output  AW  current account balance (registered)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a transaction commits
- err  output  1  one-cycle pulse when a transaction is rejected
- err_code  output  2  held until the next grant: 0 zero-amount, 1 insufficient funds, 2 overflow, 3 withdraw limit
- count_up  output  1  one-cycle pulse coincident with done for deposits only
- sess_end  output  1  one-cycle pulse on timeout or card removal

Behaviour:
- Reset, asynchronous on res: state IDLE; balance=0; wd_cnt=0; idle timer=0; last_grant=withdraw; done, err, count_up, sess_end, busy=0; err_code=0.
- States: IDLE, CHECK, UPDATE, RESP. All outputs are registered.
- IDLE:
  - With card_in=0, requests are ignored and the timer is held at 0.
  - With card_in=1 and a request present, capture amount and the request type, then go to CHECK.
  - If both requests arrive together, grant the type that was not granted last time (alternating priority), then toggle last_grant.
- CHECK (1 cycle):
  - amount==0 -> error 0.
  - Withdraw with amount>balance -> error 1.
  - Deposit with balance+amount overflowing AW bits (carry out of an AW+1 sum) -> error 2.
  - Withdraw with wd_cnt==MAX_WD -> error 3.
  - Priority when several errors apply: 0 > 3 > 1 > 2.
  - On error go to RESP with err set; otherwise go to UPDATE.
- UPDATE (1 cycle): balance += amount or -= amount; a withdraw increments wd_cnt. Go to RESP.
- RESP (1 cycle): the done/count_up or err pulse is visible in this cycle. Return to IDLE.
- Latency: request sampled at edge N; done/err high during the cycle after edge N+2 (commit) or after edge N+1 (reject); back in IDLE after edge N+3.
- Requests arriving while busy are dropped, not queued.
- Card removal (card_in falls):
  - In CHECK: abort, no update, no err; go to IDLE and pulse sess_end.
  - In UPDATE or RESP: the commit completes, then sess_end pulses in the cycle after RESP.
  - Any session end clears wd_cnt and the timer; balance is retained.
- Timeout: the timer counts cycles in IDLE with card_in=1, reset by any grant. When it reaches TIMEOUT-1, pulse sess_end, clear wd_cnt, and ignore requests until card_in goes low then high again.
- A reset mid-transaction discards the transaction; balance returns to 0.

Decomposition:
- Shared package atm_pkg holds:
  - state encoding (IDLE=2'b00, CHECK=2'b01, UPDATE=2'b10, RESP=2'b11)
  - err_code constants ERR_ZERO, ERR_INSUF, ERR_OVF, ERR_LIMIT
  - request-type constant DEP/WD
- One natural sub-module: atm_sess_timer, which holds the idle timer, the card-removal edge detect, the sess_end pulse and the re-arm lockout. The FSM, arbiter and balance register stay in atm_txn_ctrl.

Test Plan:
- Reset, card_in=1, dep_req with amount=50 -> done and count_up high for 1 cycle, 3 cycles after sampling; balance=50; err=0.
- balance=50, wd_req with amount=80 -> err pulse, err_code=1, balance stays 50, wd_cnt unchanged, no count_up.
- dep_req and wd_req in the same cycle, twice in a row (amounts 10 and 5, starting balance 50) -> first grant is deposit (last_grant=withdraw after reset), second is withdraw; final balance 55.
- Four withdraws of 1 from balance 100 with MAX_WD=3 -> three commits (balance 97), the fourth gives err_code=3. Toggle card_in low/high -> the next withdraw commits (balance 96).
- Deposit of 1 with balance=16'hFFFF -> err_code=2, balance unchanged. Deposit with amount=0 -> err_code=0.
- card_in=1 idle for TIMEOUT cycles -> sess_end pulses once and the following dep_req is ignored. Separately, drop card_in in CHECK -> no balance change, sess_end pulse, back in IDLE.
